// File: rtl/hazard_detection_unit.sv
// Pipeline hazard detection: load-use and HI/LO-busy stalls, taken-branch flush,
// a multi-cycle mult/div occupancy tracker and a saturating stall counter.
module hazard_detection_unit #(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_RegisterRt,
    input  logic        ID_EX_MultDiv,
    input  logic [4:0]  IF_ID_RegisterRs,
    input  logic [4:0]  IF_ID_RegisterRt,
    input  logic        IF_ID_UsesRt,
    input  logic        IF_ID_UsesHiLo,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Bubble,
    output logic        md_busy,
    output logic [15:0] stall_count
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic load_use;
    logic hilo_hazard;
    logic stall;

    always_comb begin
        load_use    = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                      ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                       (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));
        hilo_hazard = (state_q == MD_BUSY) && IF_ID_UsesHiLo;
        stall       = (load_use || hilo_hazard) && !BranchTaken;
    end

    always_comb begin
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;
        stall_count_d = stall_count_q;
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Bubble  = 1'b0;

        // A mult/div paired with a taken branch is older than the branch, so it still occupies the unit.
        case (state_q)
            RUN: begin
                if (ID_EX_MultDiv) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_LOAD;
                end
            end
            MD_BUSY: begin
                md_cnt_d = md_cnt_q - 4'd1;
                if (md_cnt_q == 4'd1) begin
                    state_d  = RUN;
                    md_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = 4'd0;
            end
        endcase

        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end

        if (!reset) begin
            if (BranchTaken) begin
                IF_ID_Flush  = 1'b1;
                ID_EX_Bubble = 1'b1;
            end else if (stall) begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            md_cnt_q      <= 4'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign md_busy     = (state_q == MD_BUSY);
    assign stall_count = stall_count_q;

endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 The block SHALL have a parameter MD_LATENCY, default 4, giving the number of EX cycles a mult/div occupies (legal range 2..15).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port ID_EX_MemRead, input, 1, meaning the instruction in EX is a load.
REQ-005 The block SHALL have port ID_EX_RegisterRt, input, 5, the load destination register in EX.
REQ-006 The block SHALL have port ID_EX_MultDiv, input, 1, meaning the instruction in EX is a mult/div entering its first EX cycle.
REQ-007 The block SHALL have port IF_ID_RegisterRs, input, 5, the ID-stage source register rs.
REQ-008 The block SHALL have port IF_ID_RegisterRt, input, 5, the ID-stage source register rt.
REQ-009 The block SHALL have port IF_ID_UsesRt, input, 1, meaning the ID instruction reads rt as a source.
REQ-010 The block SHALL have port IF_ID_UsesHiLo, input, 1, meaning the ID instruction is mfhi/mflo/mult/div.
REQ-011 The block SHALL have port BranchTaken, input, 1, meaning a branch or jump resolved as taken in EX.
REQ-012 The block SHALL have port PCWrite, output, 1, the PC load enable.
REQ-013 The block SHALL have port IF_ID_Write, output, 1, the IF/ID register load enable.
REQ-014 The block SHALL have port IF_ID_Flush, output, 1, which zeroes IF/ID (nop).
REQ-015 The block SHALL have port ID_EX_Bubble, output, 1, which zeroes the ID/EX control fields.
REQ-016 The block SHALL have port md_busy, output, 1, registered, asserted while the mult/div unit is occupied.
REQ-017 The block SHALL have port stall_count, output, 16, registered, a count of stall cycles.

Function
REQ-018 The block SHALL keep a registered state in {RUN, MD_BUSY} and a 4-bit down-counter md_cnt.
REQ-019 The block SHALL detect load-use when ID_EX_MemRead=1, ID_EX_RegisterRt!=0, and (ID_EX_RegisterRt==IF_ID_RegisterRs, or (IF_ID_UsesRt=1 and ID_EX_RegisterRt==IF_ID_RegisterRt)).
REQ-020 The block SHALL detect hilo_hazard when state=MD_BUSY and IF_ID_UsesHiLo=1.
REQ-021 The block SHALL assert stall = (load_use or hilo_hazard) and BranchTaken=0; stall is combinational in the same cycle.
REQ-022 While stall=1, the block SHALL drive PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, and IF_ID_Flush=0.
REQ-023 While BranchTaken=1, the block SHALL drive IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1, and IF_ID_Write=1; the branch SHALL override any stall in that cycle.
REQ-024 Otherwise, the block SHALL drive PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, and ID_EX_Bubble=0.
REQ-025 A load-use stall SHALL last exactly one cycle: the inserted bubble clears ID_EX_MemRead on the next cycle, and the block holds no extra state for it.
REQ-026 RUN→MD_BUSY SHALL occur on ID_EX_MultDiv=1 with BranchTaken=0, loading md_cnt=MD_LATENCY-1.
REQ-027 In MD_BUSY, md_cnt SHALL decrement by 1 each cycle; the block SHALL go to RUN on the edge where md_cnt==1 (total MD_BUSY residence MD_LATENCY-1 cycles).
REQ-028 A mult/div cannot enter EX while in MD_BUSY, because hilo_hazard stalls it; any ID_EX_MultDiv=1 in MD_BUSY SHALL be ignored.
REQ-029 If ID_EX_MultDiv=1 and BranchTaken=1 occur together, the block SHALL still enter MD_BUSY, since the mult/div is older than the branch.
REQ-030 md_busy SHALL equal (state==MD_BUSY).
REQ-031 stall_count SHALL increment by 1 on every edge where stall=1 and SHALL saturate at 16'hFFFF, not wrapping.
REQ-032 Simultaneous load_use and hilo_hazard SHALL count as one stall cycle.

Reset
REQ-033 On a clk edge with reset=1, the block SHALL set state=RUN, md_cnt=0, md_busy=0, and stall_count=0, aborting any MD_BUSY in progress.
REQ-034 While reset=1, the block SHALL force combinational outputs to PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, and ID_EX_Bubble=0, regardless of the other inputs.
REQ-035 After reset deasserts, the first cycle SHALL behave as RUN with no pending state.

Verification
REQ-036 Load-use: ID_EX_MemRead=1, ID_EX_RegisterRt=6, IF_ID_RegisterRs=6 -> the same cycle gives PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; the next cycle, with MemRead=0, gives all enables 1; stall_count=1.
REQ-037 $zero and unused rt: ID_EX_RegisterRt=0 matching Rs, then ID_EX_RegisterRt=12 equal to IF_ID_RegisterRt=12 with IF_ID_UsesRt=0 -> no stall in either case.
REQ-038 Mult/div: ID_EX_MultDiv=1 with MD_LATENCY=4 -> md_busy=1 for 3 cycles; IF_ID_UsesHiLo=1 held throughout -> 3 stall cycles, then release; stall_count=3.
REQ-039 Branch priority: load-use condition and BranchTaken=1 in the same cycle -> IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1; stall_count unchanged.
REQ-040 Reset mid-operation: reset=1 during the second MD_BUSY cycle -> the next edge gives md_busy=0, stall_count=0, state=RUN; IF_ID_UsesHiLo=1 then causes no stall.
REQ-041 Saturation: force 65535 stall cycles, then 3 more -> stall_count stays 16'hFFFF.
